// File: rtl/uart_frame_transmitter_pkg.sv
// Shared UART constants and the transmit FSM state encoding (also used by the receiver).
package uart_frame_transmitter_pkg;
   localparam int unsigned UART_CLKS_PER_BIT = 1250;
   localparam int unsigned UART_DATA_BITS    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/uart_frame_transmitter_if.sv
// Byte handshake between the classifier (master) and the UART transmitter (slave).
interface uart_frame_transmitter_if;
   import uart_frame_transmitter_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_valid;
   logic                      tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO buffering transmit data; pointers wrap modulo DEPTH.
module uart_tx_fifo
   import uart_frame_transmitter_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                      sysclk,
   input  logic                      reset,
   input  logic [UART_DATA_BITS-1:0] din,
   input  logic                      push,
   output logic [UART_DATA_BITS-1:0] dout,
   input  logic                      pop,
   output logic [CNT_W-1:0]          count,
   output logic                      full,
   output logic                      empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [UART_DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]             wr_ptr;
   logic [AW-1:0]             rd_ptr;
   logic                      do_push;
   logic                      do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage array: written on accepted pushes only, no reset needed.
   always_ff @(posedge sysclk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_frame_transmitter.sv
// UART 8N1 transmitter: buffers handshake bytes in a FIFO and serialises them LSB-first.
module uart_frame_transmitter
   import uart_frame_transmitter_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  sysclk,
   input  logic                  reset,
   uart_frame_transmitter_if.slave tx,
   output logic                  uart_rxd_out,
   output logic                  tx_busy,
   output logic [CNT_W-1:0]      fifo_count
);
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = $clog2(UART_DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

   tx_state_t                 state, state_nx;
   logic [BAUD_W-1:0]         baud, baud_nx;
   logic [IDX_W-1:0]          bit_idx, bit_idx_nx;
   logic [UART_DATA_BITS-1:0] shift_reg, shift_nx;
   logic                      line_nx;
   logic                      pop;
   logic                      push;
   logic                      baud_done;
   logic [UART_DATA_BITS-1:0] fifo_dout;
   logic                      fifo_full;
   logic                      fifo_empty;

   assign tx.tx_ready = !fifo_full;
   assign push        = tx.tx_valid && !fifo_full;
   assign baud_done   = (baud == BAUD_LAST);
   assign tx_busy     = (state != IDLE);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .sysclk (sysclk),
      .reset  (reset),
      .din    (tx.tx_data),
      .push   (push),
      .dout   (fifo_dout),
      .pop    (pop),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // State, counters, shift register and the registered serial line.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         baud         <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         uart_rxd_out <= 1'b1;
      end else begin
         state        <= state_nx;
         baud         <= baud_nx;
         bit_idx      <= bit_idx_nx;
         shift_reg    <= shift_nx;
         uart_rxd_out <= line_nx;
      end
   end

   // Next-state logic; the line level is derived from the next state so the output flop is glitch-free.
   always_comb begin
      state_nx   = state;
      baud_nx    = baud;
      bit_idx_nx = bit_idx;
      shift_nx   = shift_reg;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            baud_nx    = '0;
            bit_idx_nx = '0;
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_nx = fifo_dout;
               state_nx = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_nx  = '0;
               state_nx = DATA;
            end else begin
               baud_nx = baud + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_nx  = '0;
               shift_nx = shift_reg >> 1;
               if (bit_idx == IDX_LAST) begin
                  bit_idx_nx = '0;
                  state_nx   = STOP;
               end else begin
                  bit_idx_nx = bit_idx + 1'b1;
               end
            end else begin
               baud_nx = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_nx  = '0;
               state_nx = IDLE;
            end else begin
               baud_nx = baud + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      case (state_nx)
         START:   line_nx = 1'b0;
         DATA:    line_nx = shift_nx[0];
         default: line_nx = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Directed bench: scoreboard of accepted bytes, frames decoded from the serial line at mid-bit.
module tb_uart_frame_transmitter;
   import uart_frame_transmitter_pkg::*;

   localparam int unsigned FAST_CPB = 16;
   localparam int unsigned SLOW_CPB = 1250;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic       line_f, busy_f, line_s, busy_s;
   logic [2:0] cnt_f, cnt_s;

   int         total  = 0;
   int         passed = 0;
   logic [7:0] sb_q [$];

   uart_frame_transmitter_if if_f ();
   uart_frame_transmitter_if if_s ();

   uart_frame_transmitter #(.CLKS_PER_BIT(FAST_CPB), .FIFO_DEPTH(4), .CNT_W(3)) dut_fast (
      .sysclk       (sysclk),
      .reset        (reset),
      .tx           (if_f),
      .uart_rxd_out (line_f),
      .tx_busy      (busy_f),
      .fifo_count   (cnt_f)
   );

   uart_frame_transmitter #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(4), .CNT_W(3)) dut_slow (
      .sysclk       (sysclk),
      .reset        (reset),
      .tx           (if_s),
      .uart_rxd_out (line_s),
      .tx_busy      (busy_s),
      .fifo_count   (cnt_s)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic line(input bit sel);
      return sel ? line_s : line_f;
   endfunction

   function automatic logic rdy(input bit sel);
      return sel ? if_s.tx_ready : if_f.tx_ready;
   endfunction

   task automatic drive(input bit sel, input logic [7:0] d, input logic v);
      if (sel) begin
         if_s.tx_data  = d;
         if_s.tx_valid = v;
      end else begin
         if_f.tx_data  = d;
         if_f.tx_valid = v;
      end
   endtask

   task automatic push_byte(input bit sel, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge sysclk);
      drive(sel, d, 1'b1);
      while (rdy(sel) !== 1'b1 && n < 2000) begin
         @(negedge sysclk);
         n++;
      end
      check("push_ready_seen", n < 2000, 1);
      @(posedge sysclk);
      if (n < 2000) sb_q.push_back(d);
      @(negedge sysclk);
      drive(sel, d, 1'b0);
   endtask

   task automatic wait_start(input bit sel, input int limit, output int gap);
      gap = 0;
      while (line(sel) === 1'b1 && gap < limit) begin
         @(negedge sysclk);
         gap++;
      end
   endtask

   // Called on the first sample of the start bit; returns at the middle of the stop bit.
   task automatic decode(input bit sel);
      int unsigned cpb;
      logic [7:0]  b;
      cpb = sel ? SLOW_CPB : FAST_CPB;
      b   = '0;
      repeat (cpb / 2) @(negedge sysclk);
      check("start_bit", line(sel), 0);
      for (int i = 0; i < 8; i++) begin
         repeat (cpb) @(negedge sysclk);
         b[i] = line(sel);
      end
      repeat (cpb) @(negedge sysclk);
      check("stop_bit", line(sel), 1);
      check("sb_has_entry", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) check("rx_byte", b, sb_q.pop_front());
   endtask

   initial begin
      int gap;
      drive(0, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);

      // 1. reset
      #1 reset = 1'b1;
      repeat (5) @(negedge sysclk);
      check("rst_line", line_f, 1);
      check("rst_ready", if_f.tx_ready, 1);
      check("rst_busy", busy_f, 0);
      check("rst_count", cnt_f, 0);
      check("rst_busy_slow", busy_s, 0);
      check("rst_count_slow", cnt_s, 0);
      reset = 1'b0;

      // 2. single byte, latency and frame length
      push_byte(0, 8'hA5);
      check("a5_count", cnt_f, 1);
      wait_start(0, 50, gap);
      check("a5_latency", gap, 1);
      check("a5_busy", busy_f, 1);
      check("a5_count_popped", cnt_f, 0);
      decode(0);
      repeat (7) @(negedge sysclk);
      check("a5_busy_last", busy_f, 1);
      @(negedge sysclk);
      check("a5_busy_drop", busy_f, 0);
      check("a5_line_idle", line_f, 1);

      // 3/4. burst with tx_valid held: fill, full stall, refill across pointer wrap
      fork
         begin
            logic [7:0] bytes [6];
            int         exp_cnt [6];
            int         n;
            bytes   = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h55, 8'hE7};
            exp_cnt = '{0, 1, 1, 2, 3, 4};
            for (int i = 0; i < 6; i++) begin
               @(negedge sysclk);
               drive(0, bytes[i], 1'b1);
               check("burst_count", cnt_f, exp_cnt[i]);
               check("burst_ready", rdy(0), (i != 5));
               n = 0;
               while (rdy(0) !== 1'b1 && n < 400) begin
                  @(negedge sysclk);
                  n++;
               end
               check("burst_waited", n > 0, (i == 5));
               check("burst_wait_bound", n < 400, 1);
               @(posedge sysclk);
               if (n < 400) sb_q.push_back(bytes[i]);
            end
            @(negedge sysclk);
            drive(0, 8'h00, 1'b0);
            check("burst_refill_full", cnt_f, 4);
         end
         begin
            int g;
            for (int i = 0; i < 6; i++) begin
               wait_start(0, 400, g);
               check("burst_start_seen", g < 400, 1);
               if (i > 0) check("burst_idle_gap", g, FAST_CPB / 2 + 1);
               if (g < 400) decode(0);
            end
         end
      join

      // 5. reset in the middle of data bit 3
      repeat (20) @(negedge sysclk);
      push_byte(0, 8'h96);
      wait_start(0, 50, gap);
      check("x96_latency", gap, 1);
      repeat (4 * FAST_CPB + FAST_CPB / 2) @(negedge sysclk);
      check("x96_bit3", line_f, 0);
      #2 reset = 1'b1;
      #1;
      check("async_line", line_f, 1);
      check("async_busy", busy_f, 0);
      check("async_count", cnt_f, 0);
      sb_q.delete();
      repeat (2) @(negedge sysclk);
      reset = 1'b0;
      wait_start(0, 20 * FAST_CPB, gap);
      check("no_resume", gap, 20 * FAST_CPB);
      push_byte(0, 8'h42);
      wait_start(0, 50, gap);
      check("x42_latency", gap, 1);
      decode(0);

      // 6. tx_valid while full is ignored
      fork
         begin
            push_byte(0, 8'h11);
            push_byte(0, 8'h22);
            push_byte(0, 8'h33);
            push_byte(0, 8'h44);
            push_byte(0, 8'h55);
            @(negedge sysclk);
            check("full_count", cnt_f, 4);
            check("full_ready", rdy(0), 0);
            drive(0, 8'hEE, 1'b1);
            @(negedge sysclk);
            drive(0, 8'hEE, 1'b0);
            check("full_ignore", cnt_f, 4);
         end
         begin
            int g;
            for (int i = 0; i < 5; i++) begin
               wait_start(0, 400, g);
               check("full_start_seen", g < 400, 1);
               if (g < 400) decode(0);
            end
         end
      join
      wait_start(0, 400, gap);
      check("no_extra_frame", gap, 400);
      check("sb_drained", sb_q.size(), 0);
      check("drained_count", cnt_f, 0);

      // default bit period
      push_byte(1, 8'hA5);
      wait_start(1, 50, gap);
      check("slow_latency", gap, 1);
      decode(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
